// File: rtl/risc_pkg.sv
// Shared types and widths for the accumulator-based risc_core.
package risc_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    // Instruction opcodes, IR[7:5]
    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_FETCH,
        ST_LOADIR,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_e;

    // Opcodes whose operand must be read from memory before EXEC
    function automatic logic reads_operand(input opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU for the accumulator instructions ADD/AND/XOR/LDA.
module risc_alu
    import risc_pkg::*;
(
    input  opcode_e           opcode,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] result
);

    // Select the new accumulator value; non-ALU opcodes pass ACC through
    always_comb begin
        result = acc;
        case (opcode)
            OP_ADD:  result = acc + operand;
            OP_AND:  result = acc & operand;
            OP_XOR:  result = acc ^ operand;
            OP_LDA:  result = operand;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/risc_core.sv
// Multi-cycle accumulator core: 4-cycle FETCH/LOADIR/DECODE/EXEC sequence
// against a 32x8 synchronous-read memory, with a terminal HALT state.
module risc_core
    import risc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 5'h00
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              halt,
    output logic              zero,
    output logic [ADDR_W-1:0] pc_dbg
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              halt_q, halt_d;

    opcode_e           op;
    logic [ADDR_W-1:0] operand_addr;
    logic [DATA_W-1:0] alu_result;

    assign op           = opcode_e'(ir_q[7:5]);
    assign operand_addr = ir_q[ADDR_W-1:0];

    risc_alu u_alu (
        .opcode  (op),
        .acc     (acc_q),
        .operand (mem_rdata),
        .result  (alu_result)
    );

    // Next-state logic for FSM, PC, IR and ACC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_LOADIR;
            end
            ST_LOADIR: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = (op == OP_HLT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op)
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: acc_d = alu_result;
                    OP_JMP:  pc_d = operand_addr;
                    OP_SKZ:  if (acc_q == '0) pc_d = pc_q + ADDR_W'(1);
                    default: ;
                endcase
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        halt_d = (state_d == ST_HALT);
    end

    // State registers, asynchronously cleared by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            acc_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            halt_q  <= halt_d;
        end
    end

    // Memory interface decoded from state/PC/IR/ACC only. The FETCH read is
    // gated by rst so the bus is idle while reset holds the core in FETCH,
    // and the first fetch starts in the cycle reset is released.
    always_comb begin
        mem_addr  = pc_q;
        mem_wdata = acc_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (state_q)
            ST_FETCH:  mem_rd = ~rst;
            ST_LOADIR: mem_rd = 1'b1;
            ST_DECODE: begin
                mem_addr = operand_addr;
                mem_rd   = reads_operand(op);
            end
            ST_EXEC: begin
                if (op == OP_STO) begin
                    mem_addr = operand_addr;
                    mem_wr   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign halt   = halt_q;
    assign zero   = (acc_q == '0);
    assign pc_dbg = pc_q;

endmodule

// File: tb/tb_risc_core.sv
// Scoreboard bench for risc_core: a 32x8 sync-read memory model, expected
// fetch addresses and memory writes queued per program and checked by a
// bus monitor, plus direct checks of halt/zero/PC/ACC.
module tb_risc_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_rd, mem_wr, halt, zero;
    logic [4:0] pc_dbg;

    int n_cmp = 0;
    int n_err = 0;
    int wr_count = 0;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    logic [4:0] exp_fetch[$];
    wr_t        exp_wr[$];

    logic [7:0] mem [32];
    logic       clr = 1'b0;
    logic       ld_en = 1'b0;
    logic [4:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic       prev_rd = 1'b0;

    risc_core #(.RESET_PC(5'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .halt      (halt),
        .zero      (zero),
        .pc_dbg    (pc_dbg)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous read, write on strobe, bench load/clear port
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else begin
            if (mem_rd) mem_rdata <= mem[mem_addr];
            if (mem_wr) mem[mem_addr] <= mem_wdata;
        end
    end

    // Bus monitor: protocol checks and scoreboard pops on the falling edge
    always @(negedge clk) begin
        n_cmp++;
        if (mem_rd && mem_wr) begin
            n_err++;
            $display("FAIL rd_wr_exclusive: mem_rd=%b mem_wr=%b both high", mem_rd, mem_wr);
        end
        n_cmp++;
        if (halt && (mem_rd || mem_wr)) begin
            n_err++;
            $display("FAIL halt_bus_idle: mem_rd=%b mem_wr=%b, required 0/0 while halt", mem_rd, mem_wr);
        end
        if (!rst && mem_rd && !prev_rd) begin
            n_cmp++;
            if (exp_fetch.size() == 0) begin
                n_err++;
                $display("FAIL fetch_unexpected: fetch at %h, none expected", mem_addr);
            end else begin
                logic [4:0] ef;
                ef = exp_fetch.pop_front();
                if (mem_addr !== ef) begin
                    n_err++;
                    $display("FAIL fetch_addr: got %h, expected %h", mem_addr, ef);
                end
            end
        end
        if (mem_wr) begin
            wr_count++;
            n_cmp++;
            if (exp_wr.size() == 0) begin
                n_err++;
                $display("FAIL write_unexpected: wr addr=%h data=%h, none expected", mem_addr, mem_wdata);
            end else begin
                wr_t ew;
                ew = exp_wr.pop_front();
                if ({mem_addr, mem_wdata} !== {ew.addr, ew.data}) begin
                    n_err++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_wdata, ew.addr, ew.data);
                end
            end
        end
        prev_rd = mem_rd;
    end

    task automatic poke(input logic [4:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic hold_reset_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        wr_count = 0;
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && !halt; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (halt !== 1'b1) begin
            n_err++;
            $display("FAIL %s_halt_timeout: halt=%b after %0d cycles, expected 1", name, halt, max_cycles);
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_fetch.size() != 0 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL %s_drained: %0d fetches / %0d writes still pending, expected 0/0",
                     name, exp_fetch.size(), exp_wr.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_rd, mem_wr, halt, zero} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_ctrl: rd/wr/halt/zero=%b, expected 0001", {mem_rd, mem_wr, halt, zero});
        end
        n_cmp++;
        if (pc_dbg !== 5'h00 || mem_addr !== 5'h00) begin
            n_err++;
            $display("FAIL reset_pc: pc=%h addr=%h, expected 00/00", pc_dbg, mem_addr);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({mem_rd, mem_wr, halt, pc_dbg} !== {3'b000, 5'h00}) begin
            n_err++;
            $display("FAIL reset_hold: rd/wr/halt=%b pc=%h, expected 000/00", {mem_rd, mem_wr, halt}, pc_dbg);
        end
    endtask

    // LDA 10, ADD 11, HLT: 0x0F + 0xF3 wraps to 0x02; halt enters at cycle 12
    task automatic test_add_carry();
        hold_reset_clear();
        poke(5'h00, 8'hB0);
        poke(5'h01, 8'h51);
        poke(5'h02, 8'h00);
        poke(5'h10, 8'h0F);
        poke(5'h11, 8'hF3);
        exp_fetch.push_back(5'h00);
        exp_fetch.push_back(5'h01);
        exp_fetch.push_back(5'h02);
        release_reset();
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (halt !== 1'b0) begin
            n_err++;
            $display("FAIL carry_halt_early: halt=%b at cycle 11, expected 0", halt);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (halt !== 1'b1) begin
            n_err++;
            $display("FAIL carry_halt_cycle: halt=%b at cycle 12, expected 1", halt);
        end
        n_cmp++;
        if (dut.acc_q !== 8'h02 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL carry_acc: acc=%h zero=%b, expected 02/0", dut.acc_q, zero);
        end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (pc_dbg !== 5'h03 || halt !== 1'b1 || dut.acc_q !== 8'h02) begin
            n_err++;
            $display("FAIL carry_frozen: pc=%h halt=%b acc=%h, expected 03/1/02", pc_dbg, halt, dut.acc_q);
        end
        check_drained("carry");
    endtask

    // LDA/XOR/AND then STO: (AA ^ FF) & 3C = 14 written to 0D exactly once
    task automatic test_logic_sto();
        hold_reset_clear();
        poke(5'h00, 8'hAA);
        poke(5'h01, 8'h8B);
        poke(5'h02, 8'h6C);
        poke(5'h03, 8'hCD);
        poke(5'h04, 8'h00);
        poke(5'h0A, 8'hAA);
        poke(5'h0B, 8'hFF);
        poke(5'h0C, 8'h3C);
        for (int i = 0; i < 5; i++) exp_fetch.push_back(5'(i));
        exp_wr.push_back('{addr: 5'h0D, data: 8'h14});
        release_reset();
        wait_halt("logic", 40);
        n_cmp++;
        if (mem[5'h0D] !== 8'h14) begin
            n_err++;
            $display("FAIL sto_mem: mem[0D]=%h, expected 14", mem[5'h0D]);
        end
        n_cmp++;
        if (wr_count !== 1) begin
            n_err++;
            $display("FAIL sto_wr_cycles: mem_wr high %0d cycles, expected 1", wr_count);
        end
        n_cmp++;
        if (pc_dbg !== 5'h05) begin
            n_err++;
            $display("FAIL logic_pc: pc=%h, expected 05", pc_dbg);
        end
        check_drained("logic");
    endtask

    // SKZ;SKZ;JMP 08 with ACC=0 skips the second SKZ; with ACC=1 nothing skips
    task automatic test_skz();
        hold_reset_clear();
        poke(5'h00, 8'h20);
        poke(5'h01, 8'h20);
        poke(5'h02, 8'hE8);
        poke(5'h03, 8'h00);
        poke(5'h08, 8'h00);
        exp_fetch.push_back(5'h00);
        exp_fetch.push_back(5'h02);
        exp_fetch.push_back(5'h08);
        release_reset();
        wait_halt("skz0", 40);
        n_cmp++;
        if (pc_dbg !== 5'h09 || zero !== 1'b1) begin
            n_err++;
            $display("FAIL skz0_pc: pc=%h zero=%b, expected 09/1", pc_dbg, zero);
        end
        check_drained("skz0");

        hold_reset_clear();
        poke(5'h00, 8'hBE);
        poke(5'h01, 8'h20);
        poke(5'h02, 8'h20);
        poke(5'h03, 8'hE8);
        poke(5'h04, 8'h00);
        poke(5'h08, 8'h00);
        poke(5'h1E, 8'h01);
        for (int i = 0; i < 4; i++) exp_fetch.push_back(5'(i));
        exp_fetch.push_back(5'h08);
        release_reset();
        wait_halt("skz1", 50);
        n_cmp++;
        if (pc_dbg !== 5'h09 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL skz1_pc: pc=%h zero=%b, expected 09/0", pc_dbg, zero);
        end
        check_drained("skz1");
    endtask

    // Program patches mem[0] to HLT, jumps to 1F; PC wraps 31->0 and halts
    task automatic test_pc_wrap();
        hold_reset_clear();
        poke(5'h00, 8'hBD);
        poke(5'h01, 8'hC0);
        poke(5'h02, 8'hFF);
        poke(5'h1F, 8'hBC);
        poke(5'h1C, 8'h7E);
        poke(5'h1D, 8'h00);
        exp_fetch.push_back(5'h00);
        exp_fetch.push_back(5'h01);
        exp_fetch.push_back(5'h02);
        exp_fetch.push_back(5'h1F);
        exp_fetch.push_back(5'h00);
        exp_wr.push_back('{addr: 5'h00, data: 8'h00});
        release_reset();
        wait_halt("wrap", 60);
        n_cmp++;
        if (pc_dbg !== 5'h01 || dut.acc_q !== 8'h7E) begin
            n_err++;
            $display("FAIL wrap_state: pc=%h acc=%h, expected 01/7E", pc_dbg, dut.acc_q);
        end
        check_drained("wrap");
    endtask

    // Reset during STO EXEC: write suppressed, restart from 0 completes it
    task automatic test_reset_during_sto();
        hold_reset_clear();
        poke(5'h00, 8'hB0);
        poke(5'h01, 8'hD1);
        poke(5'h02, 8'h00);
        poke(5'h10, 8'h5A);
        exp_fetch.push_back(5'h00);
        exp_fetch.push_back(5'h01);
        release_reset();
        repeat (7) @(posedge clk);
        #1;
        n_cmp++;
        if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 5'h11, 8'h5A}) begin
            n_err++;
            $display("FAIL rst_sto_pre: wr=%b addr=%h data=%h, expected 1/11/5A", mem_wr, mem_addr, mem_wdata);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_wr, mem_rd, halt, pc_dbg, mem_addr} !== {3'b000, 5'h00, 5'h00}) begin
            n_err++;
            $display("FAIL rst_sto_async: wr/rd/halt=%b pc=%h addr=%h, expected 000/00/00",
                     {mem_wr, mem_rd, halt}, pc_dbg, mem_addr);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (mem[5'h11] !== 8'h00) begin
            n_err++;
            $display("FAIL rst_sto_nowrite: mem[11]=%h, expected 00", mem[5'h11]);
        end
        check_drained("rst_sto_pre");
        exp_fetch.push_back(5'h00);
        exp_fetch.push_back(5'h01);
        exp_fetch.push_back(5'h02);
        exp_wr.push_back('{addr: 5'h11, data: 8'h5A});
        release_reset();
        wait_halt("rst_sto", 40);
        n_cmp++;
        if (mem[5'h11] !== 8'h5A || wr_count !== 1) begin
            n_err++;
            $display("FAIL rst_sto_restart: mem[11]=%h writes=%0d, expected 5A/1", mem[5'h11], wr_count);
        end
        check_drained("rst_sto");
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_reset();
        test_logic_sto();
        test_skz();
        test_pc_wrap();
        test_reset_during_sto();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/risc_core.md
RISC_CORE -- requirements
Module: risc_core

Interface
REQ-001 Parameter RESET_PC, default 5'h00, value loaded into PC on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mem_addr  output  5  address to 32x8 memory.
REQ-005 mem_wdata  output  8  write data to memory.
REQ-006 mem_rdata  input  8  memory read data; valid the cycle after mem_rd is sampled high (synchronous read).
REQ-007 mem_rd  output  1  memory read strobe.
REQ-008 mem_wr  output  1  memory write strobe.
REQ-009 halt  output  1  high while the core is in the HALT state.
REQ-010 zero  output  1  high when ACC == 8'h00.
REQ-011 pc_dbg  output  5  current PC value, for debug.

Function
REQ-012 Instruction format is 8 bits: [7:5] opcode, [4:0] operand address.
REQ-013 Opcodes are: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
REQ-014 The FSM states are FETCH, LOADIR, DECODE, EXEC and HALT.
REQ-015 The non-halt states cycle FETCH->LOADIR->DECODE->EXEC->FETCH, so every non-HLT instruction takes exactly 4 cycles.
REQ-016 FETCH: mem_addr=PC, mem_rd=1.
REQ-017 LOADIR: mem_rd=1 (holds the read), IR<=mem_rdata, PC<=PC+1.
REQ-018 PC arithmetic wraps modulo 32 (31+1 -> 0).
REQ-019 DECODE: mem_addr=IR[4:0]; mem_rd=1 only for ADD/AND/XOR/LDA, else 0.
REQ-020 EXEC ADD: ACC<=ACC+mem_rdata, 8-bit, carry discarded.
REQ-021 EXEC AND: ACC<=ACC&mem_rdata.
REQ-022 EXEC XOR: ACC<=ACC^mem_rdata.
REQ-023 EXEC LDA: ACC<=mem_rdata.
REQ-024 EXEC STO: mem_addr=IR[4:0], mem_wdata=ACC, mem_wr=1 for exactly one cycle; ACC unchanged.
REQ-025 EXEC JMP: PC<=IR[4:0].
REQ-026 EXEC SKZ: if ACC==0 then PC<=PC+1 (wrapping), else PC unchanged.
REQ-027 HLT: at the end of DECODE the FSM enters HALT instead of EXEC.
REQ-028 HALT: mem_rd=0, mem_wr=0, halt=1; the core stays in HALT until rst; PC and ACC are frozen.
REQ-029 mem_rd and mem_wr are never high in the same cycle.
REQ-030 mem_wr is high only in EXEC with a STO instruction.
REQ-031 mem_addr, mem_wdata, mem_rd, mem_wr and halt are Moore outputs: functions of state, PC, IR and ACC only, with no combinational path from mem_rdata.
REQ-032 In states where no address is specified, mem_addr=PC.
REQ-033 In states where no write data is specified, mem_wdata=ACC.
REQ-034 zero is combinational from ACC.

Reset
REQ-035 While rst is high: state=FETCH, PC=RESET_PC, IR=8'h00, ACC=8'h00.
REQ-036 While rst is high: mem_rd=0, mem_wr=0, halt=0, zero=1.
REQ-037 Reset asserted in any state, including EXEC with STO, drops mem_wr asynchronously with no partial write beyond the current edge.
REQ-038 After reset deasserts, the first FETCH occurs on the next cycle with mem_addr=RESET_PC.

Structure
REQ-039 Package risc_pkg holds: opcode constants, the FSM state enumeration, and the widths ADDR_W=5 and DATA_W=8.
REQ-040 One combinational sub-module, risc_alu (inputs opcode, ACC, operand; output result), implements ADD/AND/XOR/LDA.
REQ-041 The FSM, PC, IR and ACC reside in risc_core.

Verification
REQ-042 Program LDA 5'h10 (mem[10]=8'h0F), ADD 5'h11 (mem[11]=8'hF3), HLT -> ACC=8'h02 (carry dropped), halt=1 at cycle 12 after reset release.
REQ-043 Program LDA 10 (8'hAA), XOR 11 (8'hFF), AND 12 (8'h3C), STO 13, HLT -> mem[13]=8'h14; mem_wr high for exactly one cycle.
REQ-044 ACC=0 then SKZ; SKZ; JMP 5'h08 -> first SKZ skips the second SKZ, so JMP is executed; with ACC=8'h01 instead, no skip occurs.
REQ-045 JMP 5'h1F at address 5'h1F with mem[0]=HLT; place JMP 5'h1F-target code so PC wraps 31->0 -> next fetch at mem_addr=5'h00, then halt=1.
REQ-046 Assert rst during EXEC of STO -> mem_wr falls asynchronously, state=FETCH, PC=RESET_PC; after release execution restarts from address 0.
REQ-047 All scenarios -> assertion that mem_rd&mem_wr never both high, and no mem_rd/mem_wr activity while halt=1.
